// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants, fetch FSM states and the IF/ID pipeline record.
package cpu_pkg;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam logic [ADDR_WIDTH-1:0] DEFAULT_RESET_PC = 32'd96;
    localparam logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0;

    typedef enum logic {FETCH, HOLD} fetch_state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc4;
        logic                  valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: '0, valid: 1'b0};
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: instruction-memory req/ack handshake.
interface fetch_stage_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master(output req, addr, input ack, rdata);
    modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_stage_pc_reg.sv
// pc_reg: program counter with sync reset and load enable.
module pc_reg #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'd96
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] d,
    output logic [ADDR_W-1:0] q
);
    always_ff @(posedge clk)
        if (reset)
            q <= RESET_PC;
        else if (load)
            q <= d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner, imem requester and IF/ID register loader with stall/redirect handling.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          ADDR_W   = ADDR_WIDTH,
    parameter int          DATA_W   = DATA_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_stage_if.master     imem,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc4,
    output logic              if_id_valid
);
    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] pc_d;
    logic              pc_load;
    logic              redir_pend;
    logic [ADDR_W-1:0] redir_target;
    if_id_t            hold_buf;
    if_id_t            if_id;

    assign pc4 = pc + ADDR_W'(4);
    // In FETCH the PC moves only on ack; in HOLD only a redirect moves it.
    assign pc_load = (state == FETCH) ? imem.ack : redirect_valid;
    assign pc_d = redirect_valid ? redirect_pc : redir_pend ? redir_target : pc4;

    pc_reg #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) u_pc (
        .clk  (clk),
        .reset(reset),
        .load (pc_load),
        .d    (pc_d),
        .q    (pc)
    );

    assign imem.req  = (state == FETCH);
    assign imem.addr = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FETCH;
            redir_pend   <= 1'b0;
            redir_target <= '0;
            hold_buf     <= '0;
            if_id        <= '0;
        end else if (state == FETCH) begin
            if (redirect_valid) begin
                if_id        <= IF_ID_BUBBLE;
                redir_pend   <= ~imem.ack;
                redir_target <= redirect_pc;
            end else if (imem.ack && redir_pend) begin
                redir_pend <= 1'b0;
                if (!stall)
                    if_id <= IF_ID_BUBBLE;
            end else if (imem.ack && stall) begin
                hold_buf <= '{instr: imem.rdata, pc4: pc4, valid: 1'b1};
                state    <= HOLD;
            end else if (imem.ack) begin
                if_id <= '{instr: imem.rdata, pc4: pc4, valid: 1'b1};
            end else if (!stall) begin
                if_id <= IF_ID_BUBBLE;
            end
        end else begin
            if (redirect_valid) begin
                if_id    <= IF_ID_BUBBLE;
                hold_buf <= '0;
                state    <= FETCH;
            end else if (!stall) begin
                if_id <= hold_buf;
                state <= FETCH;
            end
        end
    end

    assign if_id_instr = if_id.instr;
    assign if_id_pc4   = if_id.pc4;
    assign if_id_valid = if_id.valid;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a cycle-tagged IF/ID scoreboard.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    typedef struct {
        int unsigned cyc;
        logic        v;
        logic [31:0] i;
        logic [31:0] p;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    fetch_stage_if #(.ADDR_W(32), .DATA_W(32)) imem ();

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem          (imem),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: drive inputs, queue the IF/ID contents expected after the edge.
    task automatic step(input logic ack, input logic [31:0] rdata, input logic st,
                        input logic rv, input logic [31:0] rpc,
                        input logic ev, input logic [31:0] ei, input logic [31:0] ep);
        imem.ack       = ack;
        imem.rdata     = rdata;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
        sb.push_back('{cyc + 1, ev, ei, ep});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bus(input string name, input logic req, input logic [31:0] addr);
        chk({name, ".req"}, 32'(imem.req), 32'(req));
        chk({name, ".addr"}, imem.addr, addr);
    endtask

    // Monitor: compares IF/ID each cycle against the entry tagged for that cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            cyc++;
            #3;
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                e = sb.pop_front();
                errors++;
                $display("FAIL scoreboard: entry for cycle %0d never compared", e.cyc);
            end
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("if_id_valid", 32'(if_id_valid), 32'(e.v));
                chk("if_id_instr", if_id_instr, e.i);
                if (e.v)
                    chk("if_id_pc4", if_id_pc4, e.p);
            end
        end
    end

    initial begin
        imem.ack   = 1'b0;
        imem.rdata = '0;
        // Reset, then a back-to-back stream
        reset = 1'b1;
        step(1, 32'h99, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk_bus("reset", 1, 96);
        step(1, 32'h11, 0, 0, 0, 1, 32'h11, 100);
        chk_bus("stream0", 1, 100);
        step(1, 32'h22, 0, 0, 0, 1, 32'h22, 104);
        chk_bus("stream1", 1, 104);
        step(1, 32'h33, 0, 0, 0, 1, 32'h33, 108);
        chk_bus("stream2", 1, 108);
        // Stall with ack: enter HOLD, ack ignored there, release emits buffer
        reset = 1'b1;
        step(1, 32'h99, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(1, 32'h11, 0, 0, 0, 1, 32'h11, 100);
        step(1, 32'hAA, 1, 0, 0, 1, 32'h11, 100);
        chk_bus("hold0", 0, 104);
        step(1, 32'hBB, 1, 0, 0, 1, 32'h11, 100);
        chk_bus("hold1", 0, 104);
        step(0, 0, 1, 0, 0, 1, 32'h11, 100);
        chk_bus("hold2", 0, 104);
        step(0, 0, 0, 0, 0, 1, 32'hAA, 104);
        chk_bus("release", 1, 104);
        // Slow memory at 100 with redirect during the wait
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step(1, 32'h11, 0, 0, 0, 1, 32'h11, 100);
        step(0, 0, 0, 1, 200, 0, 0, 0);
        chk_bus("wait0", 1, 100);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk_bus("wait1", 1, 100);
        step(1, 32'hCC, 0, 0, 0, 0, 0, 0);
        chk_bus("redir_applied", 1, 200);
        step(1, 32'hDD, 0, 0, 0, 1, 32'hDD, 204);
        chk_bus("after_redir", 1, 204);
        // Redirect beats stall, ack data dropped
        step(1, 32'hEE, 1, 1, 300, 0, 0, 0);
        chk_bus("redir_stall", 1, 300);
        // Latest pending redirect wins
        step(0, 0, 0, 1, 400, 0, 0, 0);
        step(0, 0, 0, 1, 500, 0, 0, 0);
        chk_bus("pend", 1, 300);
        step(1, 32'h12, 0, 0, 0, 0, 0, 0);
        chk_bus("latest_wins", 1, 500);
        step(1, 32'h34, 0, 0, 0, 1, 32'h34, 504);
        // Reset while in HOLD discards the buffer
        step(1, 32'h56, 1, 0, 0, 1, 32'h34, 504);
        chk_bus("hold_pre_reset", 0, 508);
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        chk_bus("reset_in_hold", 1, 96);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // PC wrap at the top of the address space
        step(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0);
        step(1, 32'h99, 0, 0, 0, 0, 0, 0);
        chk_bus("top_addr", 1, 32'hFFFF_FFFC);
        step(1, 32'h78, 0, 0, 0, 1, 32'h78, 0);
        chk_bus("wrap", 1, 0);
        // Redirect in HOLD flushes even with stall held
        step(1, 32'h9A, 1, 0, 0, 1, 32'h78, 0);
        chk_bus("hold_wrap", 0, 4);
        step(0, 0, 1, 1, 600, 0, 0, 0);
        chk_bus("hold_redir", 1, 600);
        step(1, 32'hBC, 0, 0, 0, 1, 32'hBC, 604);
        chk_bus("post_hold_redir", 1, 604);
        imem.ack = 1'b0;
        repeat (2) @(posedge clk);
        #4;
        chk("scoreboard_left", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
